// File: rtl/accel_sequencer.sv
// Frame sequencer: walks each frame through LOAD -> PROC -> DRAIN -> IDLE,
// counts stream beats, enforces a PROC timeout and keeps sticky done/err status.
module accel_sequencer #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic             cmd_clear,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_beat,
  input  logic             in_last,
  input  logic             proc_done,
  input  logic             out_beat,
  output logic [1:0]       state,
  output logic             state_cnvt,
  output logic             load_en,
  output logic             proc_start,
  output logic             out_en,
  output logic             out_last,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, PROC = 2'b10, DRAIN = 2'b11} st_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  st_t             st, st_n;
  logic [LEN_W-1:0] len_q, len_n, beat_n, last_idx;
  logic [TO_W-1:0]  to_cnt, to_n;
  logic             done_n;
  logic [1:0]       err_n;

  assign last_idx = len_q - LEN_W'(1);
  assign state    = st;
  assign load_en  = (st == LOAD);
  assign out_en   = (st == DRAIN);
  assign busy     = (st != IDLE);
  assign out_last = (st == DRAIN) && (beat_cnt == last_idx);

  always_comb begin
    st_n   = st;
    beat_n = beat_cnt;
    len_n  = len_q;
    to_n   = to_cnt;
    done_n = done;
    err_n  = err;
    if (cmd_abort) begin
      // abort also swallows any start/clear issued in the same cycle
      if (st != IDLE) begin
        st_n   = IDLE;
        beat_n = '0;
      end
    end else begin
      if (cmd_clear && !(cmd_start && st == IDLE)) begin
        done_n = 1'b0;
        err_n  = 2'b00;
      end
      case (st)
        IDLE: if (cmd_start) begin
          if (cfg_len != '0) begin
            len_n  = cfg_len;
            beat_n = '0;
            done_n = 1'b0;
            err_n  = 2'b00;
            st_n   = LOAD;
          end else begin
            err_n = 2'b11;
          end
        end
        LOAD: if (in_beat) begin
          if (beat_cnt == last_idx) begin
            beat_n = '0;
            to_n   = '0;
            st_n   = PROC;
          end else if (in_last) begin
            err_n  = 2'b01;
            beat_n = '0;
            st_n   = IDLE;
          end else begin
            beat_n = beat_cnt + LEN_W'(1);
          end
        end
        PROC: begin
          to_n = to_cnt + TO_W'(1);
          // proc_start marks the entry cycle, where a stale proc_done is ignored
          if (proc_done && !proc_start) begin
            beat_n = '0;
            st_n   = DRAIN;
          end else if (to_cnt == TO_LAST) begin
            err_n = 2'b10;
            st_n  = IDLE;
          end
        end
        DRAIN: if (out_beat) begin
          if (out_last) begin
            done_n = 1'b1;
            beat_n = '0;
            st_n   = IDLE;
          end else begin
            beat_n = beat_cnt + LEN_W'(1);
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      st         <= IDLE;
      beat_cnt   <= '0;
      len_q      <= '0;
      to_cnt     <= '0;
      done       <= 1'b0;
      err        <= 2'b00;
      state_cnvt <= 1'b0;
      proc_start <= 1'b0;
    end else begin
      st         <= st_n;
      beat_cnt   <= beat_n;
      len_q      <= len_n;
      to_cnt     <= to_n;
      done       <= done_n;
      err        <= err_n;
      state_cnvt <= (st_n != st);
      proc_start <= (st_n == PROC) && (st != PROC);
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed-vector bench for accel_sequencer with hand-computed expectations.
module tb_accel_sequencer;

  localparam int LEN_W = 16;

  logic             aclk = 1'b0;
  logic             areset, cmd_start, cmd_abort, cmd_clear;
  logic [LEN_W-1:0] cfg_len;
  logic             in_beat, in_last, proc_done, out_beat;
  logic [1:0]       state, err;
  logic             state_cnvt, load_en, proc_start, out_en, out_last, busy, done;
  logic [LEN_W-1:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  accel_sequencer #(.LEN_W(LEN_W), .TIMEOUT(16), .TO_W(5)) dut (
    .aclk(aclk), .areset(areset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_clear(cmd_clear), .cfg_len(cfg_len), .in_beat(in_beat), .in_last(in_last),
    .proc_done(proc_done), .out_beat(out_beat), .state(state), .state_cnvt(state_cnvt),
    .load_en(load_en), .proc_start(proc_start), .out_en(out_en), .out_last(out_last),
    .beat_cnt(beat_cnt), .busy(busy), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock, land 1 time unit after the edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset = 1'b1; cmd_start = 0; cmd_abort = 0; cmd_clear = 0; cfg_len = '0;
    in_beat = 0; in_last = 0; proc_done = 0; out_beat = 0;
    tick(); tick();
    chk("rst_state", state, 0);      chk("rst_cnvt", state_cnvt, 0);
    chk("rst_flags", {load_en, proc_start, out_en, out_last, busy, done}, 0);
    chk("rst_err", err, 0);          chk("rst_beat", beat_cnt, 0);
    areset = 1'b0;

    // nominal 4-word frame
    cmd_start = 1; cfg_len = 4; tick(); cmd_start = 0;
    chk("f1_load", state, 1);        chk("f1_cnvt_load", state_cnvt, 1);
    chk("f1_load_en", load_en, 1);   chk("f1_busy", busy, 1);
    in_beat = 1; tick();
    chk("f1_beat1", beat_cnt, 1);    chk("f1_cnvt_off", state_cnvt, 0);
    tick(); tick(); in_last = 1; tick(); in_beat = 0; in_last = 0;
    chk("f1_proc", state, 2);        chk("f1_pstart", proc_start, 1);
    chk("f1_cnvt_proc", state_cnvt, 1);
    tick(); tick();
    chk("f1_proc_wait", state, 2);   chk("f1_pstart_off", proc_start, 0);
    proc_done = 1; tick(); proc_done = 0;
    chk("f1_drain", state, 3);       chk("f1_out_en", out_en, 1);
    chk("f1_cnvt_drain", state_cnvt, 1);
    out_beat = 1; tick(); tick();
    chk("f1_no_last", out_last, 0);
    tick();
    chk("f1_last", out_last, 1);
    tick(); out_beat = 0;
    chk("f1_idle", state, 0);        chk("f1_done", done, 1);
    chk("f1_err", err, 0);           chk("f1_cnvt_idle", state_cnvt, 1);
    tick();
    chk("f1_cnvt_end", state_cnvt, 0);

    // short frame: tlast on 3rd beat of 8
    cmd_start = 1; cfg_len = 8; tick(); cmd_start = 0;
    chk("f2_done_clr", done, 0);
    in_beat = 1; tick(); tick(); in_last = 1; tick(); in_beat = 0; in_last = 0;
    chk("f2_idle", state, 0);        chk("f2_err", err, 1);
    chk("f2_beat", beat_cnt, 0);     chk("f2_pstart", proc_start, 0);
    chk("f2_done", done, 0);

    // timeout in PROC (TIMEOUT=16)
    cmd_start = 1; cfg_len = 1; tick(); cmd_start = 0;
    in_beat = 1; in_last = 1; tick(); in_beat = 0; in_last = 0;
    chk("f3_proc", state, 2);
    repeat (15) tick();
    chk("f3_still_proc", state, 2);
    tick();
    chk("f3_idle", state, 0);        chk("f3_err", err, 2);

    // zero-length start then clear
    cmd_start = 1; cfg_len = 0; tick(); cmd_start = 0;
    chk("f4_state", state, 0);       chk("f4_err", err, 3);
    chk("f4_cnvt", state_cnvt, 0);
    cmd_clear = 1; tick(); cmd_clear = 0;
    chk("f4_clear", err, 0);

    // stale proc_done on PROC entry, then abort mid-drain
    cmd_start = 1; cfg_len = 5; tick(); cmd_start = 0;
    in_beat = 1; repeat (4) tick(); in_last = 1; proc_done = 1; tick();
    in_beat = 0; in_last = 0;
    chk("f5_proc", state, 2);
    tick();
    chk("f5_stale_ignored", state, 2);
    tick(); proc_done = 0;
    chk("f5_drain", state, 3);       chk("f5_cnvt", state_cnvt, 1);
    out_beat = 1; tick(); tick(); out_beat = 0;
    chk("f5_beat2", beat_cnt, 2);
    cmd_abort = 1; tick(); cmd_abort = 0;
    chk("f5_abort_idle", state, 0);  chk("f5_out_en", out_en, 0);
    chk("f5_done", done, 0);         chk("f5_abort_beat", beat_cnt, 0);
    cmd_start = 1; cmd_abort = 1; cfg_len = 3; tick(); cmd_start = 0; cmd_abort = 0;
    chk("f5_start_abort", state, 0); chk("f5_busy", busy, 0);

    // reset mid-LOAD, then start while busy
    cmd_start = 1; cfg_len = 6; tick(); cmd_start = 0;
    in_beat = 1; tick(); tick(); in_beat = 0;
    chk("f6_beat", beat_cnt, 2);
    areset = 1; tick(); areset = 0;
    chk("f6_rst_state", state, 0);   chk("f6_rst_beat", beat_cnt, 0);
    chk("f6_rst_flags", {state_cnvt, load_en, proc_start, out_en, out_last, busy, done}, 0);
    chk("f6_rst_err", err, 0);
    cmd_start = 1; cfg_len = 3; tick();
    chk("f6_load", state, 1);
    cfg_len = 9; in_beat = 1; tick(); cmd_start = 0;
    chk("f6_busy_start", state, 1);  chk("f6_beat1", beat_cnt, 1);
    tick(); in_last = 1; tick(); in_beat = 0; in_last = 0;
    chk("f6_len_kept", state, 2);
    cmd_abort = 1; tick(); cmd_abort = 0;
    chk("f6_abort", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
